// File: rtl/ae_pkg.sv
// Shared definitions for the autoencoder datapath sequencer: opcodes, ALU
// select codes, sequencer state encoding and instruction field positions.
package ae_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;
    localparam logic [1:0] SEL_MUL = 2'b10;

    localparam int OPC_MSB  = 15;
    localparam int DST_MSB  = 11;
    localparam int DST_LSB  = 8;
    localparam int SRCA_MSB = 7;
    localparam int SRCA_LSB = 4;
    localparam int SRCB_MSB = 3;
    localparam int SRCB_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_WB     = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

    // Non-ALU opcodes map to add so the select never floats to an unused code
    function automatic logic [1:0] alu_sel_of(input logic [3:0] op);
        logic [1:0] sel;
        case (op)
            OP_SUB:  sel = SEL_SUB;
            OP_MUL:  sel = SEL_MUL;
            default: sel = SEL_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// ALU response watchdog: counts cycles while enabled and flags expiry once
// TIMEOUT-1 has been reached; cleared when a new ALU operation is launched.
module seq_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: saturates at LAST so a late alu_done cannot wrap it
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/alu_sequencer.sv
// Program sequencer: fetches and decodes instructions, launches ALU ops,
// waits for completion under a watchdog and issues the write-back strobe.
module alu_sequencer
    import ae_pkg::*;
#(
    parameter int OP_WIDTH = 4,
    parameter int PC_WIDTH = 8,
    parameter int PROG_LEN = 256,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_data,
    output logic [3:0]          rf_addr_a,
    output logic [3:0]          rf_addr_b,
    output logic                alu_en,
    output logic [1:0]          alu_op_sel,
    output logic                alu_start,
    input  logic                alu_done,
    output logic                mem_we,
    output logic [3:0]          mem_waddr,
    output logic                wb_sel
);

    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(PROG_LEN - 1);

    seq_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic                err_q, err_d;
    logic [OP_WIDTH-1:0] dec_op_s;
    logic [OP_WIDTH-1:0] cur_op_s;
    logic                wd_expired_s;

    logic busy_q, done_q, alu_en_q, alu_start_q, mem_we_q, wb_sel_q;
    logic [1:0] alu_op_sel_q;

    assign dec_op_s = imem_data[OPC_MSB -: OP_WIDTH];
    assign cur_op_s = instr_d[OPC_MSB -: OP_WIDTH];

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == ST_EXEC),
        .en_i      (state_q == ST_WAIT),
        .expired_o (wd_expired_s)
    );

    // Next-state, pc, instruction and error logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                instr_d = imem_data;
                if (is_alu_op(dec_op_s)) begin
                    state_d = ST_EXEC;
                end else if (dec_op_s == OP_STORE) begin
                    state_d = ST_WB;
                end else if (dec_op_s == OP_HALT) begin
                    state_d = ST_DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_EXEC: state_d = ST_WAIT;
            ST_WAIT: begin
                // alu_done wins over an expiry landing in the same cycle
                if (alu_done) begin
                    state_d = ST_WB;
                end else if (wd_expired_s) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WB: begin
                if (pc_q == LAST_PC) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers plus outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            instr_q      <= 16'h0000;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            alu_en_q     <= 1'b0;
            alu_start_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            alu_op_sel_q <= SEL_ADD;
            wb_sel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            err_q        <= err_d;
            busy_q       <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done_q       <= (state_d == ST_DONE);
            alu_en_q     <= (state_d == ST_EXEC) || (state_d == ST_WAIT);
            alu_start_q  <= (state_d == ST_EXEC);
            mem_we_q     <= (state_d == ST_WB);
            alu_op_sel_q <= alu_sel_of(cur_op_s);
            wb_sel_q     <= (cur_op_s == OP_STORE);
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign imem_addr  = pc_q;
    assign rf_addr_a  = instr_q[SRCA_MSB:SRCA_LSB];
    assign rf_addr_b  = instr_q[SRCB_MSB:SRCB_LSB];
    assign alu_en     = alu_en_q;
    assign alu_op_sel = alu_op_sel_q;
    assign alu_start  = alu_start_q;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = instr_q[DST_MSB:DST_LSB];
    assign wb_sel     = wb_sel_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: an instruction-level interpreter expands each
// program into the expected per-cycle outputs and the alu_done stimulus.
module tb_alu_sequencer;

    localparam int PLEN = 3;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst, start, alu_done;
    logic        busy, done, err, alu_en, alu_start, mem_we, wb_sel;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [3:0]  rf_addr_a, rf_addr_b, mem_waddr;
    logic [1:0]  alu_op_sel;

    logic [15:0] rom [0:255];
    int          dly [0:255];

    always #5 clk = ~clk;

    // Synchronous instruction ROM
    always @(posedge clk) imem_data <= rom[imem_addr];

    alu_sequencer #(.OP_WIDTH(4), .PC_WIDTH(8), .PROG_LEN(PLEN), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .imem_addr(imem_addr), .imem_data(imem_data), .rf_addr_a(rf_addr_a),
        .rf_addr_b(rf_addr_b), .alu_en(alu_en), .alu_op_sel(alu_op_sel),
        .alu_start(alu_start), .alu_done(alu_done), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .wb_sel(wb_sel)
    );

    typedef struct packed {
        logic       busy, done, err;
        logic [7:0] addr;
        logic       en, stt, we;
        logic [3:0] waddr, ra, rb;
        logic       wbs, opchk;
        logic [1:0] opsel;
        logic       ad, st;
    } ent_t;

    ent_t       tr[$];
    ent_t       ce;
    int         cur;
    logic       chk_en = 1'b0;
    bit         noise = 1'b0;
    int         n_pass = 0, n_tot = 0;
    int         cnt_en, cnt_stt, cnt_we, first_we;
    logic [3:0] obs_wa[$];
    logic [1:0] obs_op[$];
    logic       obs_wb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic rnd();
        return noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    function automatic logic [3:0] wa(input int i);
        if (i < obs_wa.size()) return obs_wa[i];
        return 4'bxxxx;
    endfunction

    function automatic logic [1:0] op_at(input int i);
        if (i < obs_op.size()) return obs_op[i];
        return 2'bxx;
    endfunction

    // Interpret the program in rom/dly and expand it into expected cycles
    task automatic build();
        int pc = 0;
        bit fin = 0, er = 0, ok, wb;
        logic [15:0] ins;
        logic [3:0]  op;
        ent_t e;
        tr.delete();
        while (!fin) begin
            ins = rom[pc];
            op  = ins[15:12];
            e = '0; e.busy = 1'b1; e.addr = 8'(pc);
            e.ad = rnd(); e.st = rnd(); tr.push_back(e);
            e.ad = rnd(); e.st = rnd(); tr.push_back(e);
            wb = 0;
            if (op <= 4'd2) begin
                e.en = 1'b1; e.stt = 1'b1; e.opchk = 1'b1; e.opsel = op[1:0];
                e.ad = rnd(); e.st = rnd(); tr.push_back(e);
                e.stt = 1'b0; ok = 0;
                for (int w = 1; w <= TMO && !ok; w++) begin
                    e.ad = (w == dly[pc]); e.st = rnd(); tr.push_back(e);
                    ok = (w == dly[pc]);
                end
                if (ok) wb = 1;
                else begin er = 1; fin = 1; end
            end else if (op == 4'd3) begin
                wb = 1;
            end else if (op == 4'hF) begin
                fin = 1;
            end else begin
                er = 1; fin = 1;
            end
            if (wb) begin
                e = '0; e.busy = 1'b1; e.addr = 8'(pc); e.we = 1'b1;
                e.waddr = ins[11:8]; e.ra = ins[7:4]; e.rb = ins[3:0];
                e.wbs = (op == 4'd3); e.opchk = (op <= 4'd2); e.opsel = op[1:0];
                e.ad = rnd(); e.st = rnd(); tr.push_back(e);
                if (pc == PLEN - 1) fin = 1;
                else pc++;
            end
        end
        for (int t = 0; t < 3; t++) begin
            e = '0; e.done = 1'b1; e.err = er; e.addr = 8'(pc); e.ad = rnd();
            tr.push_back(e);
        end
    endtask

    task automatic run();
        build();
        obs_wa.delete(); obs_op.delete(); obs_wb.delete();
        cnt_en = 0; cnt_stt = 0; cnt_we = 0; first_we = -1;
        @(posedge clk); #1 start = 1'b1; alu_done = 1'b0;
        foreach (tr[j]) begin
            @(posedge clk); #1;
            start = tr[j].st; alu_done = tr[j].ad; cur = j; chk_en = 1'b1;
        end
        @(posedge clk); #1 chk_en = 1'b0; start = 1'b0; alu_done = 1'b0;
    endtask

    task automatic load(input int a, input logic [15:0] ins, input int d);
        rom[a] = ins; dly[a] = d;
    endtask

    // Per-cycle comparison against the expanded expectation
    always @(negedge clk) begin
        if (chk_en) begin
            ce = tr[cur];
            chk("ctl", {busy, done, err, imem_addr, alu_en, alu_start, mem_we},
                {ce.busy, ce.done, ce.err, ce.addr, ce.en, ce.stt, ce.we});
            if (ce.we) chk("wb", {mem_waddr, wb_sel, rf_addr_a, rf_addr_b},
                           {ce.waddr, ce.wbs, ce.ra, ce.rb});
            if (ce.opchk) chk("opsel", alu_op_sel, ce.opsel);
            if (alu_en) cnt_en++;
            if (alu_start) cnt_stt++;
            if (mem_we) begin
                if (cnt_we == 0) first_we = cur;
                cnt_we++;
                obs_wa.push_back(mem_waddr);
                obs_op.push_back(alu_op_sel);
                obs_wb.push_back(wb_sel);
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; alu_done = 1'b0;
        for (int i = 0; i < 256; i++) begin rom[i] = 16'hF000; dly[i] = 1; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", {busy, done, err, imem_addr, alu_en, alu_start, mem_we, alu_op_sel, wb_sel}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        load(0, 16'h0123, 1); load(1, 16'h1456, 1); load(2, 16'hF000, 1);
        run();
        chk("t1_we_count", cnt_we, 2);
        chk("t1_waddr", {wa(0), wa(1)}, {4'd1, 4'd4});
        chk("t1_opsel", {op_at(0), op_at(1)}, {2'b00, 2'b01});
        chk("t1_end", {done, err, imem_addr}, {1'b1, 1'b0, 8'd2});

        load(0, 16'h2789, 5); load(1, 16'hF000, 1);
        run();
        chk("t2_alu_en_cycles", cnt_en, 6);
        chk("t2_alu_start_pulses", cnt_stt, 1);
        chk("t2_waddr", {cnt_we[3:0], wa(0), op_at(0)}, {4'd1, 4'd7, 2'b10});

        load(0, 16'h3A50, 1); load(1, 16'hF000, 1);
        run();
        chk("t3_no_alu_start", cnt_stt, 0);
        chk("t3_we_cycle", first_we, 2);
        chk("t3_waddr_wbsel", {wa(0), (obs_wb.size() > 0) ? obs_wb[0] : 1'bx}, {4'd10, 1'b1});

        load(0, 16'h7000, 1);
        run();
        chk("t4_illegal", {done, err, cnt_we[3:0]}, {1'b1, 1'b1, 4'd0});
        load(0, 16'h0123, 1); load(1, 16'hF000, 1);
        run();
        chk("t4_restart", {done, err, imem_addr, wa(0)}, {1'b1, 1'b0, 8'd1, 4'd1});

        load(0, 16'h0123, 20);
        run();
        chk("t5_timeout", {done, err, cnt_we[3:0]}, {1'b1, 1'b1, 4'd0});
        chk("t5_alu_en_cycles", cnt_en, 9);

        load(0, 16'h0123, TMO); load(1, 16'hF000, 1);
        run();
        chk("t6_done_at_limit", {err, cnt_we[3:0]}, {1'b0, 4'd1});
        chk("t6_alu_en_cycles", cnt_en, 9);

        load(0, 16'h0123, 2); load(1, 16'h0456, 2); load(2, 16'h0789, 2);
        run();
        chk("t8_prog_len", {done, err, imem_addr, cnt_we[3:0]}, {1'b1, 1'b0, 8'd2, 4'd3});
        chk("t8_waddr", {wa(0), wa(1), wa(2)}, {4'd1, 4'd4, 4'd7});

        noise = 1'b1;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < PLEN; i++) begin
                logic [3:0] op;
                k = $urandom_range(0, 9);
                if (k <= 4 || k == 9) op = 4'($urandom_range(0, 2));
                else if (k <= 6) op = 4'd3;
                else if (k == 7) op = 4'hF;
                else op = 4'($urandom_range(4, 14));
                load(i, {op, 12'($urandom)}, $urandom_range(1, 10));
            end
            run();
        end
        noise = 1'b0;

        load(0, 16'h2789, 20);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (!alu_start && k < 20) begin @(negedge clk); k++; end
        chk("t7_reach_exec", alu_start, 1'b1);
        @(posedge clk); #1 rst = 1'b1; start = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("t7_rst_in_wait", {busy, done, err, imem_addr, alu_en, alu_start, mem_we, alu_op_sel, wb_sel}, 64'd0);
        @(negedge clk);
        chk("t7_stays_idle", {busy, done, mem_we}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
